activation_axis: RTL and testbench

ACTIVATION_AXIS -- requirements
Module: activation_axis

---
 rtl/activation_axis.sv | 173 +++++++++++++++++
 tb/tb_activation_axis.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/activation_axis.sv
// Per-lane activation (pass/ReLU/leaky/clip) on an AXI4-Stream path.
// Datapath: one result register, a beat FIFO, then a registered output slot.
module activation_axis #(
  parameter int unsigned SUB_ELEMENT_WIDTH = 8,
  parameter int unsigned NUM_SUB_ELEMENTS  = 4,
  parameter int unsigned NUM_PLATES        = 3,
  parameter int unsigned C_AXIS_FIFO_DEPTH = 16,
  parameter int unsigned LEAK_SHIFT        = 3,
  localparam int unsigned C_AXIS_TDATA_WIDTH = SUB_ELEMENT_WIDTH * NUM_SUB_ELEMENTS * NUM_PLATES
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic [1:0]                           mode,
  input  logic signed [SUB_ELEMENT_WIDTH-1:0]  clip_value,
  input  logic                                 s00_axis_tvalid,
  output logic                                 s00_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]        s00_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0]      s00_axis_tstrb,
  input  logic                                 s00_axis_tlast,
  input  logic                                 s00_axis_tuser,
  output logic                                 m00_axis_tvalid,
  input  logic                                 m00_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]        m00_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0]      m00_axis_tstrb,
  output logic                                 m00_axis_tlast,
  output logic                                 m00_axis_tuser,
  output logic [15:0]                          frame_count,
  output logic                                 frame_err
);

  localparam int unsigned W         = C_AXIS_TDATA_WIDTH;
  localparam int unsigned SW        = W / 8;
  localparam int unsigned SEW       = SUB_ELEMENT_WIDTH;
  localparam int unsigned LANES     = NUM_SUB_ELEMENTS * NUM_PLATES;
  localparam int unsigned BW        = W + SW + 2;
  localparam int unsigned PTR_W     = $clog2(C_AXIS_FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned CMP_W     = CNT_W + 1;
  localparam int unsigned READY_MAX = C_AXIS_FIFO_DEPTH - 2;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_IN_FRAME = 1'b1;

  logic                  accept_c;
  logic [1:0]            mode_q;
  logic signed [SEW-1:0] clip_q;
  logic [1:0]            eff_mode_c;
  logic signed [SEW-1:0] eff_clip_c;
  logic [W-1:0]          act_data_c;
  logic [0:0]            state_q;
  logic [0:0]            state_next_c;
  logic                  err_next_c;
  logic                  pipe_valid;
  logic [BW-1:0]         pipe_beat;
  logic [BW-1:0]         mem [C_AXIS_FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      fifo_cnt;
  logic [CNT_W-1:0]      cnt_next_c;
  logic                  push_c;
  logic                  pop_c;
  logic                  ready_next_c;

  function automatic logic [SEW-1:0] act_lane(input logic signed [SEW-1:0] x,
                                              input logic [1:0]            m,
                                              input logic signed [SEW-1:0] c);
    logic [SEW-1:0] r;
    r = x;
    case (m)
      2'd1: r = x[SEW-1] ? '0 : x;
      2'd2: r = x[SEW-1] ? SEW'(x >>> LEAK_SHIFT) : x;
      2'd3: begin
        if (x[SEW-1] || c[SEW-1]) r = '0;
        else if (x > c)           r = c;
        else                      r = x;
      end
      default: r = x;
    endcase
    return r;
  endfunction

  assign accept_c = s00_axis_tvalid & s00_axis_tready;

  // A start-of-frame beat uses the mode presented with it; others use the latched one
  always_comb begin
    eff_mode_c = s00_axis_tuser ? mode : mode_q;
    eff_clip_c = s00_axis_tuser ? clip_value : clip_q;
    act_data_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      act_data_c[i*SEW +: SEW] = act_lane(s00_axis_tdata[i*SEW +: SEW], eff_mode_c, eff_clip_c);
    end
  end

  always_comb begin
    state_next_c = state_q;
    err_next_c   = frame_err;
    if (accept_c) begin
      if (s00_axis_tuser) begin
        if (state_q == ST_IN_FRAME) err_next_c = 1'b1;
        state_next_c = s00_axis_tlast ? ST_IDLE : ST_IN_FRAME;
      end else begin
        if (state_q == ST_IDLE) err_next_c = 1'b1;
        if (s00_axis_tlast) state_next_c = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      frame_err <= 1'b0;
      mode_q    <= 2'd1;
      clip_q    <= '0;
    end else begin
      state_q   <= state_next_c;
      frame_err <= err_next_c;
      if (accept_c && s00_axis_tuser) begin
        mode_q <= mode;
        clip_q <= clip_value;
      end
    end
  end

  // Ready counts FIFO + result register; output slot sits outside that budget
  always_comb begin
    push_c       = pipe_valid;
    pop_c        = (fifo_cnt != '0) && (!m00_axis_tvalid || m00_axis_tready);
    cnt_next_c   = fifo_cnt + CNT_W'(push_c) - CNT_W'(pop_c);
    ready_next_c = ({1'b0, cnt_next_c} + CMP_W'(accept_c)) <= CMP_W'(READY_MAX);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pipe_valid      <= 1'b0;
      pipe_beat       <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_cnt        <= '0;
      s00_axis_tready <= 1'b0;
    end else begin
      pipe_valid      <= accept_c;
      if (accept_c) pipe_beat <= {s00_axis_tuser, s00_axis_tlast, s00_axis_tstrb, act_data_c};
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_cnt        <= cnt_next_c;
      s00_axis_tready <= ready_next_c;
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= pipe_beat;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m00_axis_tvalid <= 1'b0;
      m00_axis_tdata  <= '0;
      m00_axis_tstrb  <= '0;
      m00_axis_tlast  <= 1'b0;
      m00_axis_tuser  <= 1'b0;
      frame_count     <= '0;
    end else begin
      if (pop_c) begin
        m00_axis_tvalid <= 1'b1;
        {m00_axis_tuser, m00_axis_tlast, m00_axis_tstrb, m00_axis_tdata} <= mem[rd_ptr];
      end else if (m00_axis_tready) begin
        m00_axis_tvalid <= 1'b0;
      end
      if (m00_axis_tvalid && m00_axis_tready && m00_axis_tlast) frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_activation_axis.sv
// Scoreboard bench for activation_axis: expectations queued at accept, compared at output.
module tb_activation_axis;

  localparam int unsigned SEW   = 8;
  localparam int unsigned NSE   = 4;
  localparam int unsigned NPL   = 3;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LS    = 3;
  localparam int unsigned W     = SEW * NSE * NPL;
  localparam int unsigned SW    = W / 8;
  localparam int unsigned LANES = NSE * NPL;
  localparam int unsigned BW    = W + SW + 2;
  localparam int          LDIV  = 1 << LS;

  logic          clk = 1'b0;
  logic          resetn;
  logic [1:0]    mode;
  logic [7:0]    clip_value;
  logic          s00_axis_tvalid;
  logic          s00_axis_tready;
  logic [W-1:0]  s00_axis_tdata;
  logic [SW-1:0] s00_axis_tstrb;
  logic          s00_axis_tlast;
  logic          s00_axis_tuser;
  logic          m00_axis_tvalid;
  logic          m00_axis_tready = 1'b0;
  logic [W-1:0]  m00_axis_tdata;
  logic [SW-1:0] m00_axis_tstrb;
  logic          m00_axis_tlast;
  logic          m00_axis_tuser;
  logic [15:0]   frame_count;
  logic          frame_err;

  logic [BW-1:0]     sb_q[$];
  logic [1:0]        m_mode;
  logic signed [7:0] m_clip;
  bit                m_inframe;
  bit                m_err;
  int                n_cmp = 0;
  int                n_err = 0;
  int                sink_mode = 1;
  logic [15:0]       sb_frames = '0;
  bit                stall_q = 1'b0;
  logic [BW-1:0]     held = '0;

  activation_axis #(
    .SUB_ELEMENT_WIDTH(SEW), .NUM_SUB_ELEMENTS(NSE), .NUM_PLATES(NPL),
    .C_AXIS_FIFO_DEPTH(DEPTH), .LEAK_SHIFT(LS)
  ) dut (
    .clk(clk), .resetn(resetn), .mode(mode), .clip_value(clip_value),
    .s00_axis_tvalid(s00_axis_tvalid), .s00_axis_tready(s00_axis_tready),
    .s00_axis_tdata(s00_axis_tdata), .s00_axis_tstrb(s00_axis_tstrb),
    .s00_axis_tlast(s00_axis_tlast), .s00_axis_tuser(s00_axis_tuser),
    .m00_axis_tvalid(m00_axis_tvalid), .m00_axis_tready(m00_axis_tready),
    .m00_axis_tdata(m00_axis_tdata), .m00_axis_tstrb(m00_axis_tstrb),
    .m00_axis_tlast(m00_axis_tlast), .m00_axis_tuser(m00_axis_tuser),
    .frame_count(frame_count), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pack4(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c, input logic [7:0] d);
    return {NPL{d, c, b, a}};
  endfunction

  function automatic logic [W-1:0] rnd_data();
    logic [W-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*SEW +: SEW] = SEW'($urandom);
    return r;
  endfunction

  // Reference activation computed with plain integer arithmetic
  function automatic logic [W-1:0] act_model(input logic [W-1:0] d, input logic [1:0] md,
                                             input logic signed [7:0] cl);
    logic [W-1:0] r;
    int x, y, ceil_v;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      x = int'($signed(d[i*SEW +: SEW]));
      case (md)
        2'd0: y = x;
        2'd1: y = (x > 0) ? x : 0;
        2'd2: y = (x >= 0) ? x : (x - (LDIV - 1)) / LDIV;
        default: begin
          ceil_v = (cl < 0) ? 0 : int'(cl);
          y = (x < 0) ? 0 : x;
          if (y > ceil_v) y = ceil_v;
        end
      endcase
      r[i*SEW +: SEW] = y[SEW-1:0];
    end
    return r;
  endfunction

  task automatic model_reset();
    m_mode = 2'd1; m_clip = '0; m_inframe = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_accept(input logic [W-1:0] d, input logic [SW-1:0] st,
                              input logic lst, input logic usr);
    if (usr) begin
      if (m_inframe) m_err = 1'b1;
      m_mode = mode;
      m_clip = clip_value;
      m_inframe = !lst;
    end else begin
      if (!m_inframe) m_err = 1'b1;
      if (lst) m_inframe = 1'b0;
    end
    sb_q.push_back({usr, lst, st, act_model(d, m_mode, m_clip)});
  endtask

  task automatic send(input logic [W-1:0] d, input logic [SW-1:0] st,
                      input logic lst, input logic usr);
    int t;
    t = 0;
    @(negedge clk);
    s00_axis_tdata = d; s00_axis_tstrb = st; s00_axis_tlast = lst; s00_axis_tuser = usr;
    s00_axis_tvalid = 1'b1;
    while (!s00_axis_tready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!s00_axis_tready) begin
      chk("send_timeout", 128'(s00_axis_tready), 128'(1'b1));
      s00_axis_tvalid = 1'b0;
    end else begin
      model_accept(d, st, lst, usr);
      @(posedge clk);
      #1 s00_axis_tvalid = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 128'(sb_q.size()), 128'(0));
    repeat (3) @(negedge clk);
  endtask

  task automatic hold_check(input string tag, input logic [W-1:0] d, input logic lst,
                            input logic usr, input logic [W-1:0] expd);
    drain();
    sink_mode = 0;
    send(d, {SW{1'b1}}, lst, usr);
    repeat (3) @(negedge clk);
    chk(tag, 128'(m00_axis_tdata), 128'(expd));
    sink_mode = 1;
    drain();
  endtask

  // Sink: drives m00 ready, checks hold stability and compares popped beats
  initial begin
    logic [BW-1:0] got;
    logic [BW-1:0] exp_b;
    forever begin
      @(negedge clk);
      got = {m00_axis_tuser, m00_axis_tlast, m00_axis_tstrb, m00_axis_tdata};
      if (stall_q && resetn) begin
        chk("hold_valid", 128'(m00_axis_tvalid), 128'(1'b1));
        chk("hold_beat", 128'(got), 128'(held));
      end
      case (sink_mode)
        0:       m00_axis_tready = 1'b0;
        1:       m00_axis_tready = 1'b1;
        default: m00_axis_tready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (m00_axis_tvalid && m00_axis_tready) begin
        if (sb_q.size() == 0) chk("unexpected_beat", 128'(m00_axis_tvalid), 128'(1'b0));
        else begin
          exp_b = sb_q.pop_front();
          chk("beat", 128'(got), 128'(exp_b));
          if (exp_b[BW-2]) sb_frames++;
        end
      end
      stall_q = m00_axis_tvalid && !m00_axis_tready;
      held = got;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int i;
    bit inf;
    logic lst, usr;
    logic [W-1:0]  bp_d [20];
    logic [SW-1:0] bp_s [20];

    resetn = 1'b0; mode = 2'd0; clip_value = '0;
    s00_axis_tvalid = 1'b0; s00_axis_tdata = '0; s00_axis_tstrb = '0;
    s00_axis_tlast = 1'b0; s00_axis_tuser = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_tready", 128'(s00_axis_tready), 128'(1'b0));
    chk("rst_tvalid", 128'(m00_axis_tvalid), 128'(1'b0));
    chk("rst_tdata", 128'(m00_axis_tdata), 128'(0));
    chk("rst_frame_count", 128'(frame_count), 128'(0));
    chk("rst_frame_err", 128'(frame_err), 128'(1'b0));
    resetn = 1'b1;
    #1 chk("tready_before_edge", 128'(s00_axis_tready), 128'(1'b0));
    @(negedge clk);
    chk("tready_after_edge", 128'(s00_axis_tready), 128'(1'b1));

    // ReLU on a single-beat frame plus two-edge latency
    mode = 2'd1; clip_value = 8'd0;
    send(pack4(8'h7F, 8'h80, 8'h00, 8'hFF), {SW{1'b1}}, 1'b1, 1'b1);
    @(negedge clk); chk("lat_edge1", 128'(m00_axis_tvalid), 128'(1'b0));
    @(negedge clk); chk("lat_edge2", 128'(m00_axis_tvalid), 128'(1'b0));
    @(negedge clk); chk("lat_edge3", 128'(m00_axis_tvalid), 128'(1'b1));
    chk("relu_data", 128'(m00_axis_tdata), 128'(pack4(8'h7F, 8'h00, 8'h00, 8'h00)));

    // Leaky, mid-frame mode change ignored, clip and negative clip
    mode = 2'd2;
    hold_check("leaky", pack4(8'hF0, 8'hFF, 8'hF7, 8'h05), 1'b0, 1'b1, pack4(8'hFE, 8'hFF, 8'hFE, 8'h05));
    mode = 2'd3; clip_value = 8'd6;
    hold_check("midframe", pack4(8'hF0, 8'hFF, 8'hF7, 8'h05), 1'b1, 1'b0, pack4(8'hFE, 8'hFF, 8'hFE, 8'h05));
    hold_check("clip", pack4(8'd100, 8'hFB, 8'd6, 8'd3), 1'b1, 1'b1, pack4(8'd6, 8'd0, 8'd6, 8'd3));
    clip_value = 8'hFC;
    hold_check("clip_neg", pack4(8'd100, 8'hFB, 8'd6, 8'd3), 1'b1, 1'b1, '0);
    mode = 2'd0;
    send(rnd_data(), SW'($urandom), 1'b1, 1'b1);
    drain();
    chk("err_clean", 128'(frame_err), 128'(1'b0));

    // Backpressure: output blocked while streaming 20 beats
    sink_mode = 0; mode = 2'd0; i = 0;
    for (int k = 0; k < 20; k++) begin
      bp_d[k] = rnd_data();
      bp_s[k] = SW'($urandom);
    end
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (i < 20) begin
        s00_axis_tdata = bp_d[i]; s00_axis_tstrb = bp_s[i];
        s00_axis_tuser = (i == 0); s00_axis_tlast = (i == 19); s00_axis_tvalid = 1'b1;
        if (s00_axis_tready) begin
          model_accept(bp_d[i], bp_s[i], i == 19, i == 0);
          i++;
        end
      end
    end
    chk("bp_accepted", 128'(i), 128'(DEPTH));
    chk("bp_tready_low", 128'(s00_axis_tready), 128'(1'b0));
    sink_mode = 1;
    for (int c = 0; c < 400 && i < 20; c++) begin
      @(negedge clk);
      s00_axis_tdata = bp_d[i]; s00_axis_tstrb = bp_s[i];
      s00_axis_tuser = (i == 0); s00_axis_tlast = (i == 19); s00_axis_tvalid = 1'b1;
      if (s00_axis_tready) begin
        model_accept(bp_d[i], bp_s[i], i == 19, i == 0);
        i++;
      end
    end
    @(negedge clk);
    s00_axis_tvalid = 1'b0;
    chk("bp_all_sent", 128'(i), 128'(20));
    drain();

    // Random valid/ready over 1000 beats in well-formed frames
    sink_mode = 2; inf = 1'b0;
    for (int b = 0; b < 1000; b++) begin
      usr = !inf;
      lst = ($urandom_range(0, 3) == 0) || (b == 999);
      mode = 2'($urandom_range(0, 3));
      clip_value = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 1)) @(posedge clk);
      send(rnd_data(), SW'($urandom), lst, usr);
      inf = !lst;
    end
    sink_mode = 1;
    drain();
    chk("rand_frame_count", 128'(frame_count), 128'(sb_frames));
    chk("rand_frame_err", 128'(frame_err), 128'(m_err));

    // Protocol error: second start-of-frame before end-of-frame is sticky
    mode = 2'd1;
    send(rnd_data(), {SW{1'b1}}, 1'b0, 1'b1);
    send(rnd_data(), {SW{1'b1}}, 1'b1, 1'b1);
    drain();
    chk("err_set", 128'(frame_err), 128'(1'b1));
    send(rnd_data(), {SW{1'b1}}, 1'b1, 1'b1);
    drain();
    chk("err_sticky", 128'(frame_err), 128'(1'b1));

    // Reset mid-frame with 5 beats buffered
    sink_mode = 0; mode = 2'd0;
    send(rnd_data(), {SW{1'b1}}, 1'b0, 1'b1);
    repeat (4) send(rnd_data(), {SW{1'b1}}, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("mrst_tvalid", 128'(m00_axis_tvalid), 128'(1'b0));
    chk("mrst_tdata", 128'(m00_axis_tdata), 128'(0));
    chk("mrst_side", 128'({m00_axis_tstrb, m00_axis_tlast, m00_axis_tuser}), 128'(0));
    chk("mrst_tready", 128'(s00_axis_tready), 128'(1'b0));
    chk("mrst_frame_count", 128'(frame_count), 128'(0));
    chk("mrst_frame_err", 128'(frame_err), 128'(1'b0));
    sb_q.delete();
    model_reset();
    sb_frames = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    sink_mode = 1;
    repeat (10) @(negedge clk);
    chk("no_stale", 128'(m00_axis_tvalid), 128'(1'b0));

    mode = 2'd3; clip_value = 8'd20;
    send(rnd_data(), {SW{1'b1}}, 1'b1, 1'b1);
    send(rnd_data(), {SW{1'b1}}, 1'b0, 1'b1);
    send(rnd_data(), {SW{1'b1}}, 1'b1, 1'b0);
    mode = 2'd2;
    send(rnd_data(), {SW{1'b1}}, 1'b0, 1'b1);
    send(rnd_data(), {SW{1'b1}}, 1'b0, 1'b0);
    send(rnd_data(), {SW{1'b1}}, 1'b1, 1'b0);
    drain();
    chk("frame_count3", 128'(frame_count), 128'(16'd3));
    chk("frame_err_after", 128'(frame_err), 128'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
